// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Holds the program counter and sequences instruction fetch around the
//   branch unit. The PC advances when imem accepts a fetch. A taken, aligned
//   branch or jump from EX redirects the PC and raises a flush that lasts
//   FLUSH_CYCLES cycles, so the wrong-path instructions in IF/ID/EX are
//   squashed. A taken branch to a misaligned target is not followed. Instead
//   it raises a one-cycle misalign pulse and records the offending target.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   FLUSH_CYCLES number of cycles flush is high per redirect (>= 1),
//                including the redirect cycle itself
//   CNT_W        width of the saturating taken-redirect counter
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous reset, active-high
//   stall        hazard unit: hold the PC and issue no new fetch
//   br_valid     EX stage holds a resolved branch or jump this cycle
//   branch       branch decision (1 = taken; jumps arrive as 1)
//   br_target    redirect target address from EX
//   fetch_ready  imem accepts fetch_addr this cycle
//   fetch_req    fetch request valid
//   fetch_addr   address to fetch (the current PC)
//   flush        squash the IF/ID and ID/EX contents
//   misalign     one-cycle pulse: taken target is not 4-byte aligned
//   bad_addr     offending target, held until the next misalign
//   taken_cnt    number of applied redirects, saturating
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             branch,
  input  logic [31:0]      br_target,
  input  logic             fetch_ready,
  output logic             fetch_req,
  output logic [31:0]      fetch_addr,
  output logic             flush,
  output logic             misalign,
  output logic [31:0]      bad_addr,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // The FLUSH-state counter only needs to count up to FLUSH_CYCLES-2.
  // Keep it at least 1 bit wide so the design still elaborates when
  // FLUSH_CYCLES is 1.
  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;
  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

  logic [1:0]       state_q,     state_d;
  logic [31:0]      pc_q,        pc_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             misalign_q,  misalign_d;
  logic [31:0]      bad_addr_q,  bad_addr_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic taken_hit;
  logic target_aligned;

  assign taken_hit      = br_valid & branch;
  assign target_aligned = (br_target[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    misalign_d  = 1'b0;
    bad_addr_d  = bad_addr_q;
    taken_cnt_d = taken_cnt_q;
    fetch_req   = 1'b0;
    flush       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        fetch_req = ~stall;
        if (taken_hit && target_aligned) begin
          // A redirect overrides stall and any pending fetch. An unaccepted
          // fetch is simply withdrawn. The flush is combinational, so
          // squashing starts in the redirect cycle itself.
          flush = 1'b1;
          pc_d  = br_target;
          if (taken_cnt_q != {CNT_W{1'b1}}) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
          end
          if (MULTI_FLUSH) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end else if (taken_hit) begin
          // Misaligned target: report it, but do not follow it.
          misalign_d = 1'b1;
          bad_addr_d = br_target;
        end else if (!stall && fetch_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end

      ST_FLUSH: begin
        // br_valid is ignored here because it belongs to a squashed
        // instruction. Fetch continues from the redirected PC.
        flush     = 1'b1;
        fetch_req = ~stall;
        if (!stall && fetch_ready) begin
          pc_d = pc_q + 32'd4;
        end
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      bad_addr_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
      bad_addr_q  <= bad_addr_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign fetch_addr = pc_q;
  assign misalign   = misalign_q;
  assign bad_addr   = bad_addr_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed-vector bench for pc_sequencer with the default parameters
//   (RESET_PC = 0, FLUSH_CYCLES = 2, CNT_W = 16). Inputs change 1 ns after
//   the rising edge. Outputs are checked before the next rising edge, once
//   the combinational outputs have settled on the current inputs.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        branch;
  logic [31:0] br_target;
  logic        fetch_ready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        flush;
  logic        misalign;
  logic [31:0] bad_addr;
  logic [15:0] taken_cnt;

  int checks_cnt;
  int errors_cnt;

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_valid   (br_valid),
    .branch     (branch),
    .br_target  (br_target),
    .fetch_ready(fetch_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .misalign   (misalign),
    .bad_addr   (bad_addr),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    #2;
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    br_valid    = 1'b0;
    branch      = 1'b0;
    br_target   = 32'h0;
    fetch_ready = 1'b1;

    // Test 1: reset, one BOOT cycle, then sequential fetch.
    repeat (3) step();
    sample_point();
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_flush",     32'(flush),     32'd0);
    chk("rst_addr",      fetch_addr,     32'h0);
    chk("rst_misalign",  32'(misalign),  32'd0);
    chk("rst_bad_addr",  bad_addr,       32'h0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    rst = 1'b0;
    sample_point();
    chk("boot_fetch_req", 32'(fetch_req), 32'd0);
    step();
    sample_point();
    chk("run_fetch_req", 32'(fetch_req), 32'd1);
    chk("run_addr0",     fetch_addr,     32'h0);
    step();
    sample_point();
    chk("run_addr4",     fetch_addr,     32'h4);
    step();
    sample_point();
    chk("run_addr8",     fetch_addr,     32'h8);
    step();
    step();
    sample_point();
    chk("run_addr10",    fetch_addr,     32'h10);

    // Test 2: aligned redirect at pc=0x10. Flush lasts exactly 2 cycles.
    br_valid  = 1'b1;
    branch    = 1'b1;
    br_target = 32'h100;
    sample_point();
    chk("redir_flush_same", 32'(flush), 32'd1);
    step();
    br_valid = 1'b0;
    branch   = 1'b0;
    sample_point();
    chk("redir_flush_2nd", 32'(flush),     32'd1);
    chk("redir_addr",      fetch_addr,     32'h100);
    chk("redir_cnt",       32'(taken_cnt), 32'd1);
    step();
    sample_point();
    chk("redir_flush_end", 32'(flush),     32'd0);
    chk("redir_addr_next", fetch_addr,     32'h104);

    // Test 3: a not-taken branch under stall, then a redirect under stall.
    stall    = 1'b1;
    br_valid = 1'b1;
    branch   = 1'b0;
    sample_point();
    chk("nt_flush",     32'(flush),     32'd0);
    chk("nt_fetch_req", 32'(fetch_req), 32'd0);
    step();
    sample_point();
    chk("nt_addr_held", fetch_addr,     32'h104);
    chk("nt_cnt",       32'(taken_cnt), 32'd1);
    branch    = 1'b1;
    br_target = 32'h200;
    sample_point();
    chk("stall_redir_flush", 32'(flush), 32'd1);
    step();
    br_valid = 1'b0;
    branch   = 1'b0;
    sample_point();
    chk("stall_redir_addr", fetch_addr,     32'h200);
    chk("stall_redir_cnt",  32'(taken_cnt), 32'd2);
    step();
    stall = 1'b0;
    sample_point();
    chk("stall_flush_end", 32'(flush), 32'd0);
    chk("stall_addr_held", fetch_addr, 32'h200);
    step();
    sample_point();
    chk("stall_addr_next", fetch_addr, 32'h204);

    // Test 4: a misaligned taken target raises a one-cycle pulse and no flush.
    br_valid  = 1'b1;
    branch    = 1'b1;
    br_target = 32'h102;
    sample_point();
    chk("mis_flush", 32'(flush), 32'd0);
    step();
    br_valid = 1'b0;
    branch   = 1'b0;
    sample_point();
    chk("mis_pulse",    32'(misalign),  32'd1);
    chk("mis_bad_addr", bad_addr,       32'h102);
    chk("mis_pc_held",  fetch_addr,     32'h204);
    chk("mis_cnt",      32'(taken_cnt), 32'd2);
    step();
    sample_point();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_pc_adv",    fetch_addr,    32'h208);
    // Two misaligns back to back give two pulses.
    br_valid  = 1'b1;
    branch    = 1'b1;
    br_target = 32'h303;
    step();
    br_target = 32'h301;
    sample_point();
    chk("mis2_pulse_a", 32'(misalign), 32'd1);
    chk("mis2_bad_a",   bad_addr,      32'h303);
    step();
    br_valid = 1'b0;
    branch   = 1'b0;
    sample_point();
    chk("mis2_pulse_b", 32'(misalign), 32'd1);
    chk("mis2_bad_b",   bad_addr,      32'h301);
    step();
    sample_point();
    chk("mis2_end",   32'(misalign), 32'd0);
    chk("mis2_pc",    fetch_addr,    32'h20c);
    chk("mis2_held",  bad_addr,      32'h301);

    // Test 5: redirect to the top of the address space. The PC wraps to 0,
    // and a branch presented during FLUSH is ignored.
    br_valid  = 1'b1;
    branch    = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    br_target = 32'h400;
    sample_point();
    chk("wrap_flush", 32'(flush), 32'd1);
    chk("wrap_addr",  fetch_addr, 32'hFFFF_FFFC);
    step();
    br_valid = 1'b0;
    branch   = 1'b0;
    sample_point();
    chk("wrap_addr0",  fetch_addr,     32'h0);
    chk("wrap_cnt",    32'(taken_cnt), 32'd3);
    chk("wrap_flush0", 32'(flush),     32'd0);

    // Test 6: imem backpressure, then a reset in the middle of a FLUSH.
    fetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_point();
      chk($sformatf("bp_req_%0d", i),  32'(fetch_req), 32'd1);
      chk($sformatf("bp_addr_%0d", i), fetch_addr,     32'h0);
      step();
    end
    fetch_ready = 1'b1;
    step();
    sample_point();
    chk("bp_release", fetch_addr, 32'h4);
    br_valid  = 1'b1;
    branch    = 1'b1;
    br_target = 32'h500;
    step();
    br_valid = 1'b0;
    branch   = 1'b0;
    rst      = 1'b1;
    sample_point();
    chk("midflush_flush", 32'(flush), 32'd1);
    chk("midflush_addr",  fetch_addr, 32'h500);
    step();
    sample_point();
    chk("mrst_flush",     32'(flush),     32'd0);
    chk("mrst_addr",      fetch_addr,     32'h0);
    chk("mrst_fetch_req", 32'(fetch_req), 32'd0);
    chk("mrst_cnt",       32'(taken_cnt), 32'd0);
    chk("mrst_bad_addr",  bad_addr,       32'h0);
    rst = 1'b0;
    step();
    step();
    sample_point();
    chk("post_rst_addr", fetch_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
